// File: rtl/surf_cmd_pkg.sv
// Shared field layout and types for the SURF command unsplicer.
// Holds the CIN word field offsets/widths, the run-command encoding,
// the reserved-bit mask and the firmware-byte stream payload.
package surf_cmd_pkg;

    localparam int unsigned CMD_W      = 32;
    localparam int unsigned RUN_LSB    = 0;
    localparam int unsigned RUN_W      = 2;
    localparam int unsigned TRIG_LSB   = 2;
    localparam int unsigned TRIG_W     = 15;
    localparam int unsigned TRIG_V_BIT = 17;
    localparam int unsigned FW_LSB     = 18;
    localparam int unsigned FW_W       = 8;
    localparam int unsigned MARK_LSB   = 26;
    localparam int unsigned MARK_W     = 2;
    localparam int unsigned FW_V_BIT   = 28;
    localparam int unsigned PPS_BIT    = 29;

    localparam logic [CMD_W-1:0] RSVD_MASK = 32'hC000_0000;

    typedef enum logic [RUN_W-1:0] {
        RUNCMD_NOP   = 2'd0,
        RUNCMD_START = 2'd1,
        RUNCMD_STOP  = 2'd2,
        RUNCMD_RESET = 2'd3
    } runcmd_e;

    // Firmware stream payload: mark bits ride above the data byte.
    typedef struct packed {
        logic [MARK_W-1:0] mark;
        logic [FW_W-1:0]   data;
    } fw_item_t;

    localparam int unsigned FW_ITEM_W = $bits(fw_item_t);

endpackage

// File: rtl/surf_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   flush_i            empties the FIFO (wins over read/write)
//   wr_en_i/wr_data_i  write request; dropped when full unless a read frees a slot
//   rd_en_i            pop head (ignored when empty)
//   rd_data_o          head of queue
//   valid_o            FIFO not empty
//   drop_o             write request rejected this cycle (combinational)
module surf_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic                valid_q;
    logic                rd_fire;
    logic                wr_fire;

    // Occupancy tracking; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        rd_fire = rd_en_i && valid_q;
        wr_fire = wr_en_i && ((count_q != CNT_BITS'(DEPTH)) || rd_fire);
        drop_o  = wr_en_i && !flush_i && !wr_fire;
        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_fire) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = valid_q;

endmodule

// File: rtl/surf_cmd_unsplice.sv
// SURF-side decoder for the 32-bit spliced CIN command word.
// Registers each accepted word, then routes its fields to a run-command
// holding register, trigger and firmware-byte FIFOs, and a PPS pulse.
// Ports:
//   sysclk_i, rst_n_i                     clock, async active-low reset
//   command_i/command_valid_i             command word and slot strobe
//   command_locked_i                      link lock; loss flushes all streams
//   m_runcmd_*, m_trig_*, m_fw_*          AXI4S-min output streams
//   pps_o                                 one-cycle PPS pulse
//   fmt_err_cnt_o, ovf_cnt_o, cnt_clr_i   saturating counters and clear
module surf_cmd_unsplice
    import surf_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                sysclk_i,
    input  logic                rst_n_i,
    input  logic [CMD_W-1:0]    command_i,
    input  logic                command_valid_i,
    input  logic                command_locked_i,
    output logic [RUN_W-1:0]    m_runcmd_tdata,
    output logic                m_runcmd_tvalid,
    input  logic                m_runcmd_tready,
    output logic [TRIG_W-1:0]   m_trig_tdata,
    output logic                m_trig_tvalid,
    input  logic                m_trig_tready,
    output logic [FW_W-1:0]     m_fw_tdata,
    output logic [MARK_W-1:0]   m_fw_tuser,
    output logic                m_fw_tvalid,
    input  logic                m_fw_tready,
    output logic                pps_o,
    output logic [CNT_W-1:0]    fmt_err_cnt_o,
    output logic [CNT_W-1:0]    ovf_cnt_o,
    input  logic                cnt_clr_i
);

    localparam int unsigned SUM_W = CNT_W + 1;

    // Decode stage
    runcmd_e             dec_run_q,    dec_run_d;
    logic                dec_trig_v_q, dec_trig_v_d;
    logic [TRIG_W-1:0]   dec_trig_q,   dec_trig_d;
    logic                dec_fw_v_q,   dec_fw_v_d;
    fw_item_t            dec_fw_q,     dec_fw_d;
    logic                pps_q,        pps_d;
    logic                fmt_hit;

    // Run-command holder
    runcmd_e             run_data_q,   run_data_d;
    logic                run_valid_q,  run_valid_d;
    logic                run_ovf;
    logic                run_hs;

    // Counters
    logic [CNT_W-1:0]    fmt_cnt_q,    fmt_cnt_d;
    logic [CNT_W-1:0]    ovf_cnt_q,    ovf_cnt_d;
    logic [SUM_W-1:0]    fmt_sum;
    logic [SUM_W-1:0]    ovf_sum;
    logic [1:0]          ovf_inc;

    // FIFO hookup
    logic                flush;
    logic                trig_drop;
    logic                fw_drop;
    fw_item_t            fw_head;

    // Decode only on a strobe while locked; unaccepted slots leave nothing behind.
    always_comb begin
        dec_run_d    = RUNCMD_NOP;
        dec_trig_v_d = 1'b0;
        dec_trig_d   = '0;
        dec_fw_v_d   = 1'b0;
        dec_fw_d     = '0;
        pps_d        = 1'b0;
        fmt_hit      = 1'b0;
        if (command_valid_i && command_locked_i) begin
            dec_run_d     = runcmd_e'(command_i[RUN_LSB +: RUN_W]);
            dec_trig_v_d  = command_i[TRIG_V_BIT];
            dec_trig_d    = command_i[TRIG_LSB +: TRIG_W];
            dec_fw_v_d    = command_i[FW_V_BIT];
            dec_fw_d.data = command_i[FW_LSB +: FW_W];
            dec_fw_d.mark = command_i[MARK_LSB +: MARK_W];
            pps_d         = command_i[PPS_BIT];
            fmt_hit       = |(command_i & RSVD_MASK);
        end
    end

    // Loss of lock flushes every stream on the following edge.
    assign flush  = !command_locked_i;
    assign run_hs = run_valid_q && m_runcmd_tready;

    // Run-command holder: newest command wins; overwrite of an unconsumed one counts as overflow.
    always_comb begin
        run_data_d  = run_data_q;
        run_valid_d = run_valid_q;
        run_ovf     = 1'b0;
        if (flush) begin
            run_data_d  = RUNCMD_NOP;
            run_valid_d = 1'b0;
        end else if (dec_run_q != RUNCMD_NOP) begin
            run_ovf     = run_valid_q && !run_hs;
            run_data_d  = dec_run_q;
            run_valid_d = 1'b1;
        end else if (run_hs) begin
            run_data_d  = RUNCMD_NOP;
            run_valid_d = 1'b0;
        end
    end

    // Saturating counters; clear takes priority over any increment.
    always_comb begin
        ovf_inc = {1'b0, run_ovf} + {1'b0, trig_drop} + {1'b0, fw_drop};
        fmt_sum = {1'b0, fmt_cnt_q} + SUM_W'(fmt_hit);
        ovf_sum = {1'b0, ovf_cnt_q} + SUM_W'(ovf_inc);
        fmt_cnt_d = fmt_sum[CNT_W] ? '1 : fmt_sum[CNT_W-1:0];
        ovf_cnt_d = ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
        if (cnt_clr_i) begin
            fmt_cnt_d = '0;
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_run_q    <= RUNCMD_NOP;
            dec_trig_v_q <= 1'b0;
            dec_trig_q   <= '0;
            dec_fw_v_q   <= 1'b0;
            dec_fw_q     <= '0;
            pps_q        <= 1'b0;
            run_data_q   <= RUNCMD_NOP;
            run_valid_q  <= 1'b0;
            fmt_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            dec_run_q    <= dec_run_d;
            dec_trig_v_q <= dec_trig_v_d;
            dec_trig_q   <= dec_trig_d;
            dec_fw_v_q   <= dec_fw_v_d;
            dec_fw_q     <= dec_fw_d;
            pps_q        <= pps_d;
            run_data_q   <= run_data_d;
            run_valid_q  <= run_valid_d;
            fmt_cnt_q    <= fmt_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    surf_cmd_fifo #(
        .WIDTH (TRIG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_trig_fifo (
        .clk_i     (sysclk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush),
        .wr_en_i   (dec_trig_v_q),
        .wr_data_i (dec_trig_q),
        .rd_en_i   (m_trig_tready),
        .rd_data_o (m_trig_tdata),
        .valid_o   (m_trig_tvalid),
        .drop_o    (trig_drop)
    );

    surf_cmd_fifo #(
        .WIDTH (FW_ITEM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fw_fifo (
        .clk_i     (sysclk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush),
        .wr_en_i   (dec_fw_v_q),
        .wr_data_i (dec_fw_q),
        .rd_en_i   (m_fw_tready),
        .rd_data_o (fw_head),
        .valid_o   (m_fw_tvalid),
        .drop_o    (fw_drop)
    );

    assign m_runcmd_tdata  = run_data_q;
    assign m_runcmd_tvalid = run_valid_q;
    assign m_fw_tdata      = fw_head.data;
    assign m_fw_tuser      = fw_head.mark;
    assign pps_o           = pps_q;
    assign fmt_err_cnt_o   = fmt_cnt_q;
    assign ovf_cnt_o       = ovf_cnt_q;

endmodule

// File: tb/tb_surf_cmd_unsplice.sv
// Self-checking bench for surf_cmd_unsplice: table-driven single-word
// decode plus directed overflow, flush, overwrite and reset sequences.
// Stream outputs are checked through per-stream scoreboard queues.
module tb_surf_cmd_unsplice;

    localparam int unsigned CNT_W = 16;

    logic              sysclk_i;
    logic              rst_n_i;
    logic [31:0]       command_i;
    logic              command_valid_i;
    logic              command_locked_i;
    logic [1:0]        m_runcmd_tdata;
    logic              m_runcmd_tvalid;
    logic              m_runcmd_tready;
    logic [14:0]       m_trig_tdata;
    logic              m_trig_tvalid;
    logic              m_trig_tready;
    logic [7:0]        m_fw_tdata;
    logic [1:0]        m_fw_tuser;
    logic              m_fw_tvalid;
    logic              m_fw_tready;
    logic              pps_o;
    logic [CNT_W-1:0]  fmt_err_cnt_o;
    logic [CNT_W-1:0]  ovf_cnt_o;
    logic              cnt_clr_i;

    surf_cmd_unsplice #(
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .sysclk_i         (sysclk_i),
        .rst_n_i          (rst_n_i),
        .command_i        (command_i),
        .command_valid_i  (command_valid_i),
        .command_locked_i (command_locked_i),
        .m_runcmd_tdata   (m_runcmd_tdata),
        .m_runcmd_tvalid  (m_runcmd_tvalid),
        .m_runcmd_tready  (m_runcmd_tready),
        .m_trig_tdata     (m_trig_tdata),
        .m_trig_tvalid    (m_trig_tvalid),
        .m_trig_tready    (m_trig_tready),
        .m_fw_tdata       (m_fw_tdata),
        .m_fw_tuser       (m_fw_tuser),
        .m_fw_tvalid      (m_fw_tvalid),
        .m_fw_tready      (m_fw_tready),
        .pps_o            (pps_o),
        .fmt_err_cnt_o    (fmt_err_cnt_o),
        .ovf_cnt_o        (ovf_cnt_o),
        .cnt_clr_i        (cnt_clr_i)
    );

    initial sysclk_i = 1'b0;
    always #5 sysclk_i = ~sysclk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_fmt = 0;
    int exp_ovf = 0;

    logic [1:0]  q_run  [$];
    logic [14:0] q_trig [$];
    logic [9:0]  q_fw   [$];

    typedef struct {
        logic [31:0] word;
        logic [1:0]  run;
        logic        tv;
        logic [14:0] trig;
        logic        fv;
        logic [9:0]  fw;     // {mark, byte}
        logic        pps;
        logic        fmt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk_i);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] w);
        @(posedge sysclk_i);
        #1;
        command_i       = w;
        command_valid_i = 1'b1;
        @(posedge sysclk_i);
        #1;
        command_valid_i = 1'b0;
        command_i       = '0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while ((q_run.size() + q_trig.size() + q_fw.size()) != 0 && c < max_cycles) begin
            tick(1);
            c++;
        end
        check("drain_left", 32'(q_run.size() + q_trig.size() + q_fw.size()), 32'd0);
    endtask

    function automatic logic [31:0] mk_word(input logic [1:0] run, input logic tv, input logic [14:0] t,
                                            input logic fv, input logic [1:0] mark, input logic [7:0] b);
        mk_word = (32'(fv) << 28) | (32'(mark) << 26) | (32'(b) << 18) |
                  (32'(tv) << 17) | (32'(t) << 2) | 32'(run);
    endfunction

    // Scoreboard: every handshake must match the oldest expected item of its stream.
    always @(negedge sysclk_i) begin
        if (rst_n_i) begin
            if (m_runcmd_tvalid && m_runcmd_tready) begin
                if (q_run.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL runcmd_unexpected: got %0h expected none", m_runcmd_tdata);
                end else begin
                    check("runcmd_data", 32'(m_runcmd_tdata), 32'(q_run.pop_front()));
                end
            end
            if (m_trig_tvalid && m_trig_tready) begin
                if (q_trig.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL trig_unexpected: got %0h expected none", m_trig_tdata);
                end else begin
                    check("trig_data", 32'(m_trig_tdata), 32'(q_trig.pop_front()));
                end
            end
            if (m_fw_tvalid && m_fw_tready) begin
                if (q_fw.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL fw_unexpected: got %0h expected none", {m_fw_tuser, m_fw_tdata});
                end else begin
                    check("fw_data", 32'({m_fw_tuser, m_fw_tdata}), 32'(q_fw.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_0001, 2'd1, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[1] = '{32'h0002_48D0, 2'd0, 1'b1, 15'h1234, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[2] = '{32'h1A94_0000, 2'd0, 1'b0, 15'h0000, 1'b1, 10'h2A5, 1'b0, 1'b0};
        vecs[3] = '{32'h2000_0000, 2'd0, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b1, 1'b0};
        vecs[4] = '{32'h4000_0000, 2'd0, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[5] = '{32'h3FFF_FFFF, 2'd3, 1'b1, 15'h7FFF, 1'b1, 10'h3FF, 1'b1, 1'b0};
        vecs[6] = '{32'h0004_0006, 2'd2, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[7] = '{32'h8002_0000, 2'd0, 1'b1, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[8] = '{32'hC000_0003, 2'd3, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b1};
        vecs[9] = '{32'h0000_0000, 2'd0, 1'b0, 15'h0000, 1'b0, 10'h000, 1'b0, 1'b0};

        rst_n_i          = 1'b0;
        command_i        = '0;
        command_valid_i  = 1'b0;
        command_locked_i = 1'b1;
        m_runcmd_tready  = 1'b1;
        m_trig_tready    = 1'b1;
        m_fw_tready      = 1'b1;
        cnt_clr_i        = 1'b0;

        // Reset state
        tick(2);
        check("rst_runcmd_tvalid", 32'(m_runcmd_tvalid), 32'd0);
        check("rst_trig_tvalid",   32'(m_trig_tvalid),   32'd0);
        check("rst_fw_tvalid",     32'(m_fw_tvalid),     32'd0);
        check("rst_pps",           32'(pps_o),           32'd0);
        check("rst_fmt_cnt",       32'(fmt_err_cnt_o),   32'd0);
        check("rst_ovf_cnt",       32'(ovf_cnt_o),       32'd0);
        rst_n_i = 1'b1;
        tick(2);

        // Table: one word per entry, all streams ready
        for (int i = 0; i < 10; i++) begin
            strobe(vecs[i].word);
            if (vecs[i].run != 2'd0) q_run.push_back(vecs[i].run);
            if (vecs[i].tv) q_trig.push_back(vecs[i].trig);
            if (vecs[i].fv) q_fw.push_back(vecs[i].fw);
            if (vecs[i].fmt) exp_fmt++;
            check("vec_pps_pulse",    32'(pps_o),           32'(vecs[i].pps));
            check("vec_fmt_cnt",      32'(fmt_err_cnt_o),   32'(exp_fmt));
            check("vec_runcmd_early", 32'(m_runcmd_tvalid), 32'd0);
            tick(1);
            check("vec_pps_width",    32'(pps_o),           32'd0);
            check("vec_runcmd_lat",   32'(m_runcmd_tvalid), 32'(vecs[i].run != 2'd0));
            check("vec_trig_lat",     32'(m_trig_tvalid),   32'(vecs[i].tv));
            check("vec_fw_lat",       32'(m_fw_tvalid),     32'(vecs[i].fv));
            check("vec_ovf_cnt",      32'(ovf_cnt_o),       32'(exp_ovf));
        end
        wait_drain(10);

        // Trig FIFO fills to depth, fifth write dropped, drained in order
        m_trig_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(mk_word(2'd0, 1'b1, 15'h1234 + 15'(i), 1'b0, 2'd0, 8'd0));
            if (i < 4) q_trig.push_back(15'h1234 + 15'(i));
        end
        tick(1);
        exp_ovf = 1;
        check("trig_full_ovf",   32'(ovf_cnt_o),     32'(exp_ovf));
        check("trig_full_valid", 32'(m_trig_tvalid), 32'd1);
        check("trig_full_head",  32'(m_trig_tdata),  32'h1234);
        tick(3);
        check("trig_head_stable", 32'(m_trig_tdata), 32'h1234);
        m_trig_tready = 1'b1;
        wait_drain(20);
        tick(1);
        check("trig_empty_after", 32'(m_trig_tvalid), 32'd0);

        // One word overflowing all three streams at once
        m_runcmd_tready = 1'b0;
        m_trig_tready   = 1'b0;
        m_fw_tready     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(mk_word(2'((i % 3) + 1), 1'b1, 15'h0100 + 15'(i), 1'b1, 2'(i), 8'h10 + 8'(i)));
            if (i < 4) begin
                q_trig.push_back(15'h0100 + 15'(i));
                q_fw.push_back({2'(i), 8'h10 + 8'(i)});
            end
        end
        q_run.push_back(2'd2);
        tick(1);
        exp_ovf += 6;
        check("multi_ovf",         32'(ovf_cnt_o),      32'(exp_ovf));
        check("multi_runcmd_last", 32'(m_runcmd_tdata), 32'd2);
        m_runcmd_tready = 1'b1;
        m_trig_tready   = 1'b1;
        m_fw_tready     = 1'b1;
        wait_drain(20);

        // Clear coincident with a format-error increment: clear wins
        @(posedge sysclk_i);
        #1;
        command_i       = 32'h4000_0000;
        command_valid_i = 1'b1;
        cnt_clr_i       = 1'b1;
        @(posedge sysclk_i);
        #1;
        command_valid_i = 1'b0;
        cnt_clr_i       = 1'b0;
        exp_fmt = 0;
        exp_ovf = 0;
        check("clr_fmt", 32'(fmt_err_cnt_o), 32'(exp_fmt));
        check("clr_ovf", 32'(ovf_cnt_o),     32'(exp_ovf));
        strobe(32'h4000_0000);
        exp_fmt = 1;
        check("fmt_after_clr", 32'(fmt_err_cnt_o), 32'(exp_fmt));

        // Lock loss flushes pending fw bytes and runcmd
        m_runcmd_tready = 1'b0;
        m_fw_tready     = 1'b0;
        strobe(32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            strobe(mk_word(2'd0, 1'b0, 15'd0, 1'b1, 2'd1, 8'h40 + 8'(i)));
        end
        tick(1);
        check("pre_flush_fw_valid",  32'(m_fw_tvalid),     32'd1);
        check("pre_flush_run_valid", 32'(m_runcmd_tvalid), 32'd1);
        command_locked_i = 1'b0;
        tick(1);
        check("flush_runcmd_valid", 32'(m_runcmd_tvalid), 32'd0);
        check("flush_trig_valid",   32'(m_trig_tvalid),   32'd0);
        check("flush_fw_valid",     32'(m_fw_tvalid),     32'd0);
        check("flush_fmt_kept",     32'(fmt_err_cnt_o),   32'(exp_fmt));
        check("flush_ovf_kept",     32'(ovf_cnt_o),       32'(exp_ovf));
        command_locked_i = 1'b1;
        m_runcmd_tready  = 1'b1;
        m_fw_tready      = 1'b1;
        strobe(mk_word(2'd0, 1'b0, 15'd0, 1'b1, 2'd3, 8'h5A));
        q_fw.push_back(10'h35A);
        tick(1);
        check("relock_fw_valid", 32'(m_fw_tvalid), 32'd1);
        wait_drain(10);

        // Pending runcmd overwritten without handshake -> overflow
        m_runcmd_tready = 1'b0;
        strobe(32'h0000_0002);
        tick(1);
        strobe(32'h0000_0003);
        q_run.push_back(2'd3);
        tick(1);
        exp_ovf++;
        check("overwrite_data", 32'(m_runcmd_tdata), 32'd3);
        check("overwrite_ovf",  32'(ovf_cnt_o),      32'(exp_ovf));
        m_runcmd_tready = 1'b1;
        wait_drain(10);

        // Overwrite coinciding with handshake -> no overflow
        m_runcmd_tready = 1'b0;
        strobe(32'h0000_0002);
        q_run.push_back(2'd2);
        q_run.push_back(2'd3);
        tick(1);
        strobe(32'h0000_0003);
        m_runcmd_tready = 1'b1;
        tick(1);
        check("hs_load_valid", 32'(m_runcmd_tvalid), 32'd1);
        check("hs_load_data",  32'(m_runcmd_tdata),  32'd3);
        check("hs_load_ovf",   32'(ovf_cnt_o),       32'(exp_ovf));
        wait_drain(10);

        // Async reset in the middle of a trig drain
        m_trig_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(mk_word(2'd0, 1'b1, 15'h0ABC + 15'(i), 1'b0, 2'd0, 8'd0));
            q_trig.push_back(15'h0ABC + 15'(i));
        end
        tick(1);
        m_trig_tready = 1'b1;
        tick(1);
        rst_n_i = 1'b0;
        #1;
        q_trig.delete();
        exp_fmt = 0;
        exp_ovf = 0;
        check("arst_runcmd_tvalid", 32'(m_runcmd_tvalid), 32'd0);
        check("arst_runcmd_tdata",  32'(m_runcmd_tdata),  32'd0);
        check("arst_trig_tvalid",   32'(m_trig_tvalid),   32'd0);
        check("arst_trig_tdata",    32'(m_trig_tdata),    32'd0);
        check("arst_fw_tvalid",     32'(m_fw_tvalid),     32'd0);
        check("arst_fw_tdata",      32'({m_fw_tuser, m_fw_tdata}), 32'd0);
        check("arst_pps",           32'(pps_o),           32'd0);
        check("arst_fmt",           32'(fmt_err_cnt_o),   32'(exp_fmt));
        check("arst_ovf",           32'(ovf_cnt_o),       32'(exp_ovf));
        tick(1);
        rst_n_i = 1'b1;
        tick(1);

        // Strobe while unlocked is ignored
        command_locked_i = 1'b0;
        strobe(32'h6000_0001);
        check("unlocked_pps", 32'(pps_o),         32'd0);
        check("unlocked_fmt", 32'(fmt_err_cnt_o), 32'(exp_fmt));
        tick(1);
        check("unlocked_runcmd", 32'(m_runcmd_tvalid), 32'd0);
        command_locked_i = 1'b1;
        tick(2);

        wait_drain(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
